// File: rtl/jelly_bean_pkg.sv
// Shared types for the jelly bean taster family.
// Command/flavor/color/taste enums, the response entry and the taste rule.
package jelly_bean_pkg;

    localparam int CH_MAX_W   = 4;
    localparam int FLAV_MAX_W = 8;

    typedef enum logic [1:0] {
        NO_OP = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } command_e;

    typedef enum logic [2:0] {
        NO_FLAVOR  = 3'd0,
        APPLE      = 3'd1,
        BLUEBERRY  = 3'd2,
        BUBBLE_GUM = 3'd3,
        CHOCOLATE  = 3'd4
    } flavor_e;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        YUMMY   = 2'd1,
        YUCKY   = 2'd2
    } taste_e;

    // Wide enough for any legal channel count and flavor width.
    typedef struct packed {
        logic [CH_MAX_W-1:0]   ch;
        logic [FLAV_MAX_W-1:0] flavor;
        logic [1:0]            color;
        logic                  sugar_free;
        logic                  sour;
        taste_e                taste;
    } jelly_bean_rsp_s;

    function automatic taste_e taste_of(
        input logic [FLAV_MAX_W-1:0] flavor,
        input logic                  sour,
        input taste_e                old_taste
    );
        taste_e t;
        t = old_taste;
        if (flavor == FLAV_MAX_W'(CHOCOLATE) && sour) begin
            t = YUCKY;
        end else if (flavor != '0) begin
            t = YUMMY;
        end
        return t;
    endfunction

endpackage

// File: rtl/jelly_bean_rsp_fifo.sv
// Show-ahead response FIFO of jelly_bean_rsp_s entries.
// Push while full is accepted only together with a pop.
module jelly_bean_rsp_fifo
    import jelly_bean_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  jelly_bean_rsp_s i_data,
    output logic            o_full,
    input  logic            i_pop,
    output logic            o_empty,
    output jelly_bean_rsp_s o_data
);

    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;

    jelly_bean_rsp_s r_mem [RSP_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    // Status flags, qualified handshakes and the gated head entry.
    always_comb begin
        o_empty = (r_cnt == '0);
        o_full  = (r_cnt == CW'(RSP_DEPTH));
        w_pop   = i_pop && !o_empty;
        w_push  = i_push && (!o_full || w_pop);
        o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/jelly_bean_taster_mc.sv
// Multi-channel jelly bean taster with tagged READ responses.
// Round-robin arbiter moves pending READs into a shared response FIFO.
module jelly_bean_taster_mc
    import jelly_bean_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int FLAVOR_W  = 3,
    parameter  int CNT_W     = 8,
    parameter  int RSP_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*NUM_CH-1:0]        cmd,
    input  logic [FLAVOR_W*NUM_CH-1:0] flavor,
    input  logic [2*NUM_CH-1:0]        color,
    input  logic [NUM_CH-1:0]          sugar_free,
    input  logic [NUM_CH-1:0]          sour,
    output logic [2*NUM_CH-1:0]        taste,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [CH_W-1:0]            rsp_ch,
    output logic [FLAVOR_W-1:0]        rsp_flavor,
    output logic [1:0]                 rsp_color,
    output logic                       rsp_sugar_free,
    output logic                       rsp_sour,
    output logic [1:0]                 rsp_taste,
    input  logic                       cnt_clr,
    output logic [CNT_W*NUM_CH-1:0]    yucky_cnt,
    output logic [NUM_CH-1:0]          cnt_ovf
);

    logic [FLAVOR_W-1:0]   r_flv   [NUM_CH];
    logic [1:0]            r_col   [NUM_CH];
    taste_e                r_taste [NUM_CH];
    logic [CNT_W-1:0]      r_cnt   [NUM_CH];
    logic [NUM_CH-1:0]     r_sf;
    logic [NUM_CH-1:0]     r_so;
    logic [NUM_CH-1:0]     r_ovf;
    logic [NUM_CH-1:0]     r_pend;
    logic [CH_W-1:0]       r_rr;

    logic [NUM_CH-1:0]     w_wr;
    logic [NUM_CH-1:0]     w_rd;
    logic [NUM_CH-1:0]     w_yuck;
    taste_e                w_tnew  [NUM_CH];
    logic [FLAV_MAX_W-1:0] w_fin   [NUM_CH];

    int                    w_j;
    logic                  w_gnt_vld;
    logic [CH_W-1:0]       w_gnt;
    logic [CH_W-1:0]       w_rr_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    jelly_bean_rsp_s       w_ent;
    jelly_bean_rsp_s       w_head;
    logic                  w_unused;

    // Command decode and next taste per channel; code 3 acts as NO_OP.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_wr[c]  = (cmd[2*c +: 2] == 2'(WRITE));
            w_rd[c]  = (cmd[2*c +: 2] == 2'(READ));
            w_fin[c] = '0;
            w_fin[c][FLAVOR_W-1:0] = flavor[FLAVOR_W*c +: FLAVOR_W];
            w_tnew[c] = taste_of(w_fin[c], sour[c], r_taste[c]);
            w_yuck[c] = w_wr[c] &&
                        (taste_of(w_fin[c], sour[c], UNKNOWN) == YUCKY);
        end
    end

    // Round-robin pick: lowest pending index at or after r_rr, wrapping.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_j       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_j = int'(r_rr) + i;
            if (w_j >= NUM_CH) begin
                w_j = w_j - NUM_CH;
            end
            if (!w_gnt_vld && r_pend[w_j]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = CH_W'(w_j);
            end
        end
    end

    // Push gating and the entry built from pre-edge register values.
    always_comb begin
        w_pop  = !w_empty && rsp_ready;
        w_push = w_gnt_vld && (!w_full || w_pop);
        w_ent  = '0;
        w_ent.ch[CH_W-1:0]         = w_gnt;
        w_ent.flavor[FLAVOR_W-1:0] = r_flv[w_gnt];
        w_ent.color      = r_col[w_gnt];
        w_ent.sugar_free = r_sf[w_gnt];
        w_ent.sour       = r_so[w_gnt];
        w_ent.taste      = r_taste[w_gnt];
        if (w_gnt == CH_W'(NUM_CH - 1)) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = w_gnt + CH_W'(1);
        end
    end

    // Stored bean and taste; only a WRITE changes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_flv[c]   <= '0;
                r_col[c]   <= '0;
                r_taste[c] <= UNKNOWN;
            end
            r_sf <= '0;
            r_so <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr[c]) begin
                    r_flv[c]   <= flavor[FLAVOR_W*c +: FLAVOR_W];
                    r_col[c]   <= color[2*c +: 2];
                    r_sf[c]    <= sugar_free[c];
                    r_so[c]    <= sour[c];
                    r_taste[c] <= w_tnew[c];
                end
            end
        end
    end

    // Saturating YUCKY counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_clr) begin
                    r_cnt[c] <= '0;
                    r_ovf[c] <= 1'b0;
                end else if (w_yuck[c]) begin
                    if (&r_cnt[c]) begin
                        r_ovf[c] <= 1'b1;
                    end else begin
                        r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Pending READs and the round-robin pointer; a new READ wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_rr   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_pend[c] <= w_rd[c] ||
                             (r_pend[c] && !(w_push && (w_gnt == CH_W'(c))));
            end
            if (w_push) begin
                r_rr <= w_rr_nxt;
            end
        end
    end

    jelly_bean_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_ent),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_data  (w_head)
    );

    // Flatten per-channel state and unpack the FIFO head.
    always_comb begin
        taste     = '0;
        yucky_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            taste[2*c +: 2]           = r_taste[c];
            yucky_cnt[CNT_W*c +: CNT_W] = r_cnt[c];
        end
        cnt_ovf        = r_ovf;
        rsp_valid      = !w_empty;
        rsp_ch         = w_head.ch[CH_W-1:0];
        rsp_flavor     = w_head.flavor[FLAVOR_W-1:0];
        rsp_color      = w_head.color;
        rsp_sugar_free = w_head.sugar_free;
        rsp_sour       = w_head.sour;
        rsp_taste      = w_head.taste;
        w_unused       = ^w_head;
    end

endmodule
